// File: rtl/contador_bcd_pkg.sv
// Shared types and constants for the two-decade BCD counter.
package contador_bcd_pkg;

  // One BCD decade digit
  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t BCD_MIN = 4'd0;

  // Enabled clocks per count step when the parameter is not overridden
  localparam int unsigned PRESCALE_DEFAULT = 32'd4;

  // Any non-BCD code (A..F) is replaced by zero
  function automatic bcd_t bcd_sanitize(input bcd_t d);
    bcd_t r;
    if (d > BCD_MAX) begin
      r = BCD_MIN;
    end else begin
      r = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/contador_bcd_if.sv
// Control and count bus of the BCD counter; master drives controls, slave returns the count.
interface contador_bcd_if;
  import contador_bcd_pkg::*;

  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  bcd_t       units;
  bcd_t       tens;
  logic       tick;
  logic       carry;

  modport master (
    output en, up, load, load_val,
    input  units, tens, tick, carry
  );

  modport slave (
    input  en, up, load, load_val,
    output units, tens, tick, carry
  );

endinterface

// File: rtl/contador_bcd_digito_bcd.sv
// One BCD decade: registered digit with increment, decrement and load.
// wrap_o flags, in the same cycle, that the pending step rolls the digit over.
module digito_bcd
  import contador_bcd_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic dec_i,
  input  logic load_i,
  input  bcd_t load_val_i,
  output bcd_t digit_o,
  output logic wrap_o
);

  bcd_t digit_q;
  bcd_t digit_d;

  // Next digit value: load wins, then increment, then decrement
  always_comb begin
    digit_d = digit_q;
    wrap_o  = 1'b0;
    if (load_i) begin
      digit_d = bcd_sanitize(load_val_i);
    end else if (inc_i) begin
      if (digit_q >= BCD_MAX) begin
        digit_d = BCD_MIN;
        wrap_o  = 1'b1;
      end else begin
        digit_d = digit_q + 4'd1;
      end
    end else if (dec_i) begin
      if (digit_q == BCD_MIN) begin
        digit_d = BCD_MAX;
        wrap_o  = 1'b1;
      end else begin
        digit_d = digit_q - 4'd1;
      end
    end else begin
      digit_d = digit_q;
    end
  end

  // Digit register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o = digit_q;

endmodule

// File: rtl/contador_bcd.sv
// Two-digit BCD up/down counter with prescaler, load, tick and carry pulses.
module contador_bcd
  import contador_bcd_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT
)
(
  input  logic           clk,
  input  logic           rst_n,
  contador_bcd_if.slave  bus
);

  localparam logic [7:0] PRESCALE_LAST = 8'(PRESCALE - 32'd1);

  logic [7:0] presc_q;
  logic [7:0] presc_d;
  logic       step_s;
  logic       units_wrap_s;
  logic       tens_wrap_s;
  bcd_t       units_s;
  bcd_t       tens_s;
  logic       tick_q;
  logic       tick_d;
  logic       carry_q;
  logic       carry_d;

  // Prescaler advance and step qualification; load restarts the period
  always_comb begin
    presc_d = presc_q;
    step_s  = 1'b0;
    if (bus.load) begin
      presc_d = 8'd0;
    end else if (bus.en) begin
      if (presc_q == PRESCALE_LAST) begin
        presc_d = 8'd0;
        step_s  = 1'b1;
      end else begin
        presc_d = presc_q + 8'd1;
      end
    end else begin
      presc_d = presc_q;
    end
  end

  digito_bcd u_units (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (step_s & bus.up),
    .dec_i      (step_s & ~bus.up),
    .load_i     (bus.load),
    .load_val_i (bus.load_val[3:0]),
    .digit_o    (units_s),
    .wrap_o     (units_wrap_s)
  );

  // Tens steps only when the units digit rolls over
  digito_bcd u_tens (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (units_wrap_s & bus.up),
    .dec_i      (units_wrap_s & ~bus.up),
    .load_i     (bus.load),
    .load_val_i (bus.load_val[7:4]),
    .digit_o    (tens_s),
    .wrap_o     (tens_wrap_s)
  );

  // Pulse sources; tens can only wrap during a step, so carry implies tick
  always_comb begin
    tick_d  = step_s;
    carry_d = tens_wrap_s;
  end

  // Prescaler and pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= 8'd0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
    end
  end

  assign bus.units = units_s;
  assign bus.tens  = tens_s;
  assign bus.tick  = tick_q;
  assign bus.carry = carry_q;

endmodule

// File: tb/tb_contador_bcd.sv
// Directed bench for contador_bcd: vector table plus hand sequences for reset,
// direction change, freeze, PRESCALE=1 and a 200-step up run.
module tb_contador_bcd;

  logic clk;
  logic rst_n;

  contador_bcd_if bus0 ();
  contador_bcd_if bus1 ();

  contador_bcd #(.PRESCALE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  contador_bcd #(.PRESCALE(1)) dut_p1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] load_val;
    logic [3:0] exp_tens;
    logic [3:0] exp_units;
    logic       exp_tick;
    logic       exp_carry;
  } vec_t;

  localparam int NVEC = 31;
  vec_t vecs [NVEC];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] obs0();
    return {22'd0, bus0.tens, bus0.units, bus0.tick, bus0.carry};
  endfunction

  function automatic logic [31:0] obs1();
    return {22'd0, bus1.tens, bus1.units, bus1.tick, bus1.carry};
  endfunction

  function automatic logic [31:0] ex(input logic [3:0] t, input logic [3:0] u,
                                     input logic tk, input logic cy);
    return {22'd0, t, u, tk, cy};
  endfunction

  task automatic drive0(input logic e, input logic u, input logic l, input logic [7:0] v);
    bus0.en = e; bus0.up = u; bus0.load = l; bus0.load_val = v;
  endtask

  int        cnt;
  int        exh_err;
  int        carries;
  int        ticks;
  int        over;
  logic [9:0] seen;

  initial begin
    // en, up, load, load_val, tens, units, tick, carry
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 8'h98, 4'd9, 4'd8, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 4'd9, 4'd8, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'h00, 4'd9, 4'd8, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'h00, 4'd9, 4'd8, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h00, 4'd9, 4'd9, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'h00, 4'd9, 4'd9, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 4'd9, 4'd9, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'h00, 4'd9, 4'd9, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 4'd0, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 8'h01, 4'd0, 4'd1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 4'd1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 4'd1, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 4'd1, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 8'h00, 4'd9, 4'd9, 1'b1, 1'b1};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 8'h00, 4'd9, 4'd9, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 8'h00, 4'd9, 4'd9, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 1'b0, 1'b0, 8'h00, 4'd9, 4'd9, 1'b0, 1'b0};
    vecs[22] = '{1'b1, 1'b1, 1'b1, 8'hA7, 4'd0, 4'd7, 1'b0, 1'b0};
    vecs[23] = '{1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 4'd7, 1'b0, 1'b0};
    vecs[24] = '{1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 4'd7, 1'b0, 1'b0};
    vecs[25] = '{1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 4'd7, 1'b0, 1'b0};
    vecs[26] = '{1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 4'd8, 1'b1, 1'b0};
    vecs[27] = '{1'b1, 1'b1, 1'b1, 8'h5B, 4'd5, 4'd0, 1'b0, 1'b0};
    vecs[28] = '{1'b1, 1'b1, 1'b1, 8'hFF, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[29] = '{1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[30] = '{1'b0, 1'b1, 1'b1, 8'h42, 4'd4, 4'd2, 1'b0, 1'b0};

    rst_n = 1'b0;
    drive0(1'b1, 1'b1, 1'b0, 8'h00);
    bus1.en = 1'b0; bus1.up = 1'b1; bus1.load = 1'b0; bus1.load_val = 8'h00;

    // Reset held 3 cycles with en=1
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("reset_hold", obs0(), ex(4'd0, 4'd0, 1'b0, 1'b0));
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      if (i < 4) chk("post_reset_wait", obs0(), ex(4'd0, 4'd0, 1'b0, 1'b0));
      else       chk("post_reset_first_tick", obs0(), ex(4'd0, 4'd1, 1'b1, 1'b0));
    end

    // Table: up wrap, down wrap, load priority/sanitising, en=0
    for (int i = 0; i < NVEC; i++) begin
      drive0(vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].load_val);
      cyc();
      chk($sformatf("vec%0d", i), obs0(),
          ex(vecs[i].exp_tens, vecs[i].exp_units, vecs[i].exp_tick, vecs[i].exp_carry));
    end

    // Direction change mid-period keeps the prescaler phase (count 42)
    drive0(1'b1, 1'b1, 1'b0, 8'h00);
    cyc(); cyc();
    chk("dir_before", obs0(), ex(4'd4, 4'd2, 1'b0, 1'b0));
    bus0.up = 1'b0;
    cyc();
    chk("dir_mid", obs0(), ex(4'd4, 4'd2, 1'b0, 1'b0));
    cyc();
    chk("dir_step_down", obs0(), ex(4'd4, 4'd1, 1'b1, 1'b0));

    // Freeze after 2 prescaler clocks
    drive0(1'b1, 1'b1, 1'b1, 8'h20);
    cyc();
    drive0(1'b1, 1'b1, 1'b0, 8'h00);
    cyc(); cyc();
    bus0.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("freeze_hold", obs0(), ex(4'd2, 4'd0, 1'b0, 1'b0));
    end
    bus0.en = 1'b1;
    cyc();
    chk("unfreeze_1", obs0(), ex(4'd2, 4'd0, 1'b0, 1'b0));
    cyc();
    chk("unfreeze_2", obs0(), ex(4'd2, 4'd1, 1'b1, 1'b0));

    // Reset mid-step and mid-load
    drive0(1'b1, 1'b1, 1'b1, 8'h55);
    cyc();
    drive0(1'b1, 1'b1, 1'b0, 8'h00);
    cyc(); cyc(); cyc();
    chk("pre_reset_count", obs0(), ex(4'd5, 4'd5, 1'b0, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", obs0(), ex(4'd0, 4'd0, 1'b0, 1'b0));
    drive0(1'b1, 1'b1, 1'b1, 8'h77);
    cyc();
    chk("reset_discards_load", obs0(), ex(4'd0, 4'd0, 1'b0, 1'b0));
    rst_n = 1'b1;
    drive0(1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      if (i < 4) chk("resume_wait", obs0(), ex(4'd0, 4'd0, 1'b0, 1'b0));
      else       chk("resume_tick", obs0(), ex(4'd0, 4'd1, 1'b1, 1'b0));
    end

    // PRESCALE=1 steps on every enabled clock
    bus1.en = 1'b1; bus1.up = 1'b1; bus1.load = 1'b1; bus1.load_val = 8'h98;
    cyc();
    chk("p1_load", obs1(), ex(4'd9, 4'd8, 1'b0, 1'b0));
    bus1.load = 1'b0;
    cyc();
    chk("p1_step1", obs1(), ex(4'd9, 4'd9, 1'b1, 1'b0));
    cyc();
    chk("p1_wrap", obs1(), ex(4'd0, 4'd0, 1'b1, 1'b1));
    cyc();
    chk("p1_step3", obs1(), ex(4'd0, 4'd1, 1'b1, 1'b0));

    // 200 steps up from 00 against a reference count
    drive0(1'b1, 1'b1, 1'b1, 8'h00);
    cyc();
    drive0(1'b1, 1'b1, 1'b0, 8'h00);
    cnt = 0; exh_err = 0; carries = 0; ticks = 0; over = 0; seen = 10'd0;
    for (int k = 1; k <= 800; k++) begin
      logic etick;
      logic ecarry;
      cyc();
      etick  = ((k % 4) == 0);
      ecarry = 1'b0;
      if (etick) begin
        cnt    = (cnt + 1) % 100;
        ecarry = (cnt == 0);
      end
      if (obs0() !== ex(4'(cnt / 10), 4'(cnt % 10), etick, ecarry)) exh_err++;
      if (bus0.units > 4'd9 || bus0.tens > 4'd9) over++;
      else seen[bus0.units] = 1'b1;
      if (bus0.carry === 1'b1) carries++;
      if (bus0.tick === 1'b1) ticks++;
    end
    chk("exh_sequence_errors", 32'(exh_err), 32'd0);
    chk("exh_digit_over_9", 32'(over), 32'd0);
    chk("exh_carry_count", 32'(carries), 32'd2);
    chk("exh_tick_count", 32'(ticks), 32'd200);
    chk("exh_units_seen", {22'd0, seen}, 32'h3FF);
    chk("exh_final", obs0(), ex(4'd0, 4'd0, 1'b1, 1'b1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
